hex_dump_tx: RTL and testbench

HEX_DUMP_TX -- requirements
Module: hex_dump_tx

---
 rtl/hex_dump_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_hex_dump_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_dump_tx.sv
// Purpose : dumps a run of 16-bit command-memory words as ASCII hex lines ("XXXX\r\n") on an 8N1 serial line.
// Latency : first start bit 3 cycles after an accepted start (FETCH, LATCH, then SEND); every bit lasts DIVIDER cycles.
// Backpress: cts low holds off the next character; a character already on the line always completes.
//
// Ports:
//   clk_48, rst_             : clock (rising edge) and asynchronous active-low reset
//   start, base_addr, word_cnt : dump request; address and count are sampled with start, ignored while busy
//   cts                      : terminal ready, gates character starts only
//   rd_addr, rden, rd_data   : command-memory read port, data returned one cycle after rden
//   tx                       : serial output, idle high, LSB first
//   busy, done               : busy spans the dump; done is a one-cycle pulse at its end
//
// Build option: define HALT_STOP_EN to end the dump after the first 0x0000 word (its line is still sent).

module hex_dump_tx #(
  parameter int DIVIDER = 20000,
  parameter int ADDR_W  = 10
) (
  input  logic              clk_48,
  input  logic              rst_,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              cts,
  input  logic [15:0]       rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rden,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int               DIV_W    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);

`ifdef HALT_STOP_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t            state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;    // also drives rd_addr
  logic [ADDR_W:0]   remain_q, remain_d;  // words still to dump, including the current one
  logic [15:0]       word_q,   word_d;
  logic [2:0]        char_q,   char_d;    // 0..3 hex digits MSB first, 4 = CR, 5 = LF
  logic [3:0]        bit_q,    bit_d;     // 0 = start, 1..8 = data bits 0..7, 9 = stop
  logic [DIV_W-1:0]  div_q,    div_d;     // cycles elapsed within the current bit
  logic              active_q, active_d;  // a character is currently on the line
  logic              tx_q,     tx_d;
  logic              rden_q,   rden_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [3:0] nib;
  logic [7:0] char_byte;

  assign rd_addr = addr_q;
  assign rden    = rden_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // ASCII code of the character selected by char_q
  always_comb begin
    nib = 4'h0;
    case (char_q)
      3'd0:    nib = word_q[15:12];
      3'd1:    nib = word_q[11:8];
      3'd2:    nib = word_q[7:4];
      default: nib = word_q[3:0];
    endcase
    if (char_q == 3'd4) begin
      char_byte = 8'h0D;
    end else if (char_q == 3'd5) begin
      char_byte = 8'h0A;
    end else if (nib < 4'd10) begin
      char_byte = 8'h30 + {4'h0, nib};
    end else begin
      char_byte = 8'h37 + {4'h0, nib};   // 0x41 'A' for nibble 10
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    word_d   = word_q;
    char_d   = char_q;
    bit_d    = bit_q;
    div_d    = div_q;
    active_d = active_q;
    tx_d     = tx_q;
    rden_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          addr_d   = base_addr;
          remain_d = word_cnt;
          if (word_cnt == '0) begin
            // empty dump: report completion without touching the memory or the line
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = FETCH;
            rden_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      FETCH: begin
        state_d = LATCH;
      end

      LATCH: begin
        word_d  = rd_data;
        char_d  = 3'd0;
        state_d = SEND;
        // the start bit carries no data, so it can go out on the same edge the word is captured
        if (cts) begin
          tx_d     = 1'b0;
          active_d = 1'b1;
          bit_d    = 4'd0;
          div_d    = '0;
        end
      end

      SEND: begin
        if (!active_q) begin
          if (cts) begin
            tx_d     = 1'b0;
            active_d = 1'b1;
            bit_d    = 4'd0;
            div_d    = '0;
          end
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (bit_q != 4'd9) begin
            // moving to bit_q+1: data bit bit_q, or the stop bit after data bit 7
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : char_byte[bit_q[2:0]];
          end else if (char_q == 3'd5) begin
            // LF finished: word complete
            active_d = 1'b0;
            tx_d     = 1'b1;
            state_d  = NEXT;
          end else begin
            // stop bit finished: back-to-back start bit when the terminal is ready
            char_d = char_q + 3'd1;
            bit_d  = 4'd0;
            if (cts) begin
              tx_d = 1'b0;
            end else begin
              active_d = 1'b0;
              tx_d     = 1'b1;
            end
          end
        end
      end

      NEXT: begin
        remain_d = remain_q - (ADDR_W+1)'(1);
        addr_d   = addr_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
        if ((remain_q == (ADDR_W+1)'(1)) || (HALT_EN && (word_q == 16'h0000))) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = FETCH;
          rden_d  = 1'b1;
        end
      end

      FIN: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_48 or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      word_q   <= '0;
      char_q   <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      rden_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      word_q   <= word_d;
      char_q   <= char_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      active_q <= active_d;
      tx_q     <= tx_d;
      rden_q   <= rden_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_hex_dump_tx.sv
`timescale 1ns/1ps
module tb_hex_dump_tx;
  localparam int D  = 8;
  localparam int AW = 10;

  logic          clk_48 = 1'b0;
  logic          rst_ = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          cts = 1'b1;
  logic [15:0]   rd_data = '0;
  logic [AW-1:0] rd_addr;
  logic          rden, tx, busy, done;

  hex_dump_tx #(.DIVIDER(D), .ADDR_W(AW)) dut (
    .clk_48(clk_48), .rst_(rst_), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .cts(cts), .rd_data(rd_data), .rd_addr(rd_addr),
    .rden(rden), .tx(tx), .busy(busy), .done(done)
  );

  always #10 clk_48 = ~clk_48;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  logic [15:0] ram [0:1023];

  // synchronous memory: data valid the cycle after rden
  always @(posedge clk_48) begin
    cyc <= cyc + 1;
    if (rden) rd_data <= ram[rd_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model: expected characters, gaps and read addresses
  logic [7:0]    exp_bytes[$];
  int            exp_gaps[$];   // idle cycles before this character, -1 = not defined
  logic [AW-1:0] exp_addr[$];
  string hexs = "0123456789ABCDEF";

  task automatic build_expected(input int base, input int cnt);
    logic [15:0] w;
    int a, nibv;
    for (int i = 0; i < cnt; i++) begin
      a = (base + i) % 1024;
      w = ram[a];
      exp_addr.push_back(a[AW-1:0]);
      for (int k = 0; k < 4; k++) begin
        nibv = (int'(w) >> (12 - 4*k)) & 15;
        exp_bytes.push_back(hexs[nibv]);
        exp_gaps.push_back(k != 0 ? 0 : (i == 0 ? -1 : 3));
      end
      exp_bytes.push_back(8'h0D); exp_gaps.push_back(0);
      exp_bytes.push_back(8'h0A); exp_gaps.push_back(0);
`ifdef HALT_STOP_EN
      if (w == 16'h0000) break;
`endif
    end
  endtask

  // ---------------- line receiver: checks every cycle of every character against the model
  bit         rx_on = 1'b0, rx_ok = 1'b0, gap_chk = 1'b1;
  int         rx_c = 0, rx_b = 0, rx_g = 0;
  logic [7:0] rx_exp = '0, rx_byte = '0;
  logic       rx_expbit;
  int         chars_st = 0, chars_done = 0, last_start = 0, last_end = -100;
  int         done_cnt = 0, done_cyc = 0, idle_err = 0;

  always @(negedge clk_48) begin
    if (!rst_) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on && tx === 1'b0) begin
        rx_on = 1'b1; rx_c = 0; rx_ok = 1'b1; rx_byte = '0;
        chars_st++; last_start = cyc;
        chk("char_expected_by_model", exp_bytes.size() > 0, 1);
        if (exp_bytes.size() > 0) begin
          rx_exp = exp_bytes.pop_front();
          rx_g   = exp_gaps.pop_front();
          if (gap_chk && rx_g >= 0) chk("char_gap", cyc - last_end - 1, rx_g);
        end else begin
          rx_exp = 8'h00;
        end
      end
      if (rx_on) begin
        rx_b = rx_c / D;
        rx_expbit = (rx_b == 0) ? 1'b0 : (rx_b == 9) ? 1'b1 : rx_exp[rx_b-1];
        if (tx !== rx_expbit) rx_ok = 1'b0;
        if (rx_b >= 1 && rx_b <= 8 && (rx_c % D) == D/2) rx_byte[rx_b-1] = tx;
        rx_c++;
        if (rx_c == 10*D) begin
          rx_on = 1'b0; last_end = cyc; chars_done++;
          vectors++;
          if (!rx_ok || rx_byte !== rx_exp) begin
            miscompares++;
            $display("FAIL char %0d: got 0x%02h expected 0x%02h (per-cycle bit timing ok=%0d)",
                     chars_done, rx_byte, rx_exp, rx_ok);
          end
        end
      end
    end
    if (rst_ && rden) begin
      chk("rden_expected_by_model", exp_addr.size() > 0, 1);
      if (exp_addr.size() > 0) chk("rd_addr", rd_addr, exp_addr.pop_front());
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rst_ && !busy && tx !== 1'b1) idle_err++;
  end

  // ---------------- stimulus helpers
  int start_cyc = 0;

  task automatic tick();
    @(negedge clk_48); #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk_48); #1;
    start = 1'b1; base_addr = b; word_cnt = n; start_cyc = cyc;
    @(posedge clk_48); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int prev);
    int n = 0;
    while (done_cnt == prev && n < budget) begin tick(); n++; end
    chk("done_within_budget", done_cnt > prev, 1);
  endtask

  task automatic wait_chars(input int target_st, input int target_done, input int budget);
    int n = 0;
    while ((chars_st < target_st || chars_done < target_done) && n < budget) begin tick(); n++; end
    chk("chars_within_budget", (chars_st >= target_st) && (chars_done >= target_done), 1);
  endtask

  task automatic end_checks(input int exp_done, input int exp_chars);
    repeat (4) tick();
    chk("model_bytes_left", exp_bytes.size(), 0);
    chk("model_addr_left", exp_addr.size(), 0);
    chk("done_pulses", done_cnt, exp_done);
    chk("chars_received", chars_done, exp_chars);
    chk("busy_after_dump", busy, 0);
    chk("tx_after_dump", tx, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  logic [7:0] lit30 [6] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] lit32 [6] = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  int pd, pc, ps, stall_err;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 16'h0101 + 16'h1111);

    // reset state
    repeat (2) tick();
    chk("reset_tx", tx, 1);
    chk("reset_rden", rden, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_addr", rd_addr, 0);
    rst_ = 1'b1;
    repeat (3) tick();

    // one word 0x1A2F from address 0
    ram[0] = 16'h1A2F;
    build_expected(0, 1);
    for (int i = 0; i < 6; i++) chk("model_pin_1a2f", exp_bytes[i], lit30[i]);
    pd = done_cnt; pc = chars_done; ps = chars_st;
    do_start(10'h000, 11'd1);
    wait_chars(ps + 1, 0, 20);
    chk("first_start_bit_latency", last_start - start_cyc, 3);
    wait_done(80*D, pd);
    chk("done_latency", done_cyc - start_cyc, 60*D + 4);
    end_checks(pd + 1, pc + 6);

    // address wrap 0x3FF -> 0x000
    ram[1023] = 16'h0123;
    build_expected(1023, 2);
    chk("model_pin_addr0", exp_addr[0], 10'h3FF);
    chk("model_pin_addr1", exp_addr[1], 10'h000);
    chk("model_pin_nbytes_wrap", exp_bytes.size(), 12);
    pd = done_cnt; pc = chars_done;
    do_start(10'h3FF, 11'd2);
    wait_done(150*D, pd);
    end_checks(pd + 1, pc + 12);

    // zero word handling
    ram[5] = 16'h0000; ram[6] = 16'hBEEF;
    build_expected(5, 2);
`ifdef HALT_STOP_EN
    chk("model_pin_halt_nbytes", exp_bytes.size(), 6);
`else
    chk("model_pin_nohalt_nbytes", exp_bytes.size(), 12);
    for (int i = 0; i < 6; i++) chk("model_pin_beef", exp_bytes[6+i], lit32[i]);
`endif
    pd = done_cnt; pc = chars_done;
    do_start(10'h005, 11'd2);
    wait_done(150*D, pd);
`ifdef HALT_STOP_EN
    end_checks(pd + 1, pc + 6);
`else
    end_checks(pd + 1, pc + 12);
`endif

    // cts held low after the first character
    ram[8] = 16'hC0DE;
    build_expected(8, 1);
    gap_chk = 1'b0;
    pd = done_cnt; pc = chars_done;
    do_start(10'h008, 11'd1);
    wait_chars(0, pc + 1, 20*D);
    cts = 1'b0;
    ps = chars_st; stall_err = 0;
    for (int i = 0; i < 3*D; i++) begin
      tick();
      if (tx !== 1'b1) stall_err++;
    end
    chk("tx_low_cycles_while_cts_low", stall_err, 0);
    chk("chars_started_while_cts_low", chars_st, ps);
    cts = 1'b1;
    wait_done(80*D, pd);
    end_checks(pd + 1, pc + 6);
    gap_chk = 1'b1;

    // reset during data bit 2 of the first character, then a clean dump
    build_expected(0, 1);
    pd = done_cnt; ps = chars_st;
    do_start(10'h000, 11'd1);
    wait_chars(ps + 1, 0, 20);
    repeat (3*D + D/2) tick();
    chk("tx_low_before_reset", tx, 0);   // data bit 2 of 0x31 is 0
    rst_ = 1'b0;
    #1;
    chk("reset_mid_char_tx", tx, 1);
    chk("reset_mid_char_busy", busy, 0);
    chk("reset_mid_char_rd_addr", rd_addr, 0);
    exp_bytes.delete(); exp_gaps.delete(); exp_addr.delete();
    repeat (5) tick();
    rst_ = 1'b1;
    ps = chars_st;
    repeat (3*D) tick();
    chk("done_after_abort", done_cnt, pd);
    chk("chars_resumed_after_reset", chars_st, ps);
    chk("busy_after_reset_release", busy, 0);
    build_expected(0, 1);
    pc = chars_done;
    do_start(10'h000, 11'd1);
    wait_done(80*D, pd);
    end_checks(pd + 1, pc + 6);

    // start while busy is ignored
    build_expected(0, 1);
    pd = done_cnt; pc = chars_done;
    do_start(10'h000, 11'd1);
    repeat (20) tick();
    do_start(10'h020, 11'd5);
    wait_done(80*D, pd);
    end_checks(pd + 1, pc + 6);

    // empty dump: done soon, nothing on the line, no read
    pd = done_cnt; ps = chars_st;
    do_start(10'h055, 11'd0);
    wait_done(10, pd);
    chk("zero_cnt_done_in_1_to_2", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
    repeat (10) tick();
    chk("zero_cnt_chars", chars_st, ps);
    chk("zero_cnt_done_pulses", done_cnt, pd + 1);
    chk("zero_cnt_addr_left", exp_addr.size(), 0);

    chk("tx_low_while_not_busy_cycles", idle_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
